// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: handshake/control bundle between the multi-cycle controller and its datapath/memories.
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr;
    logic             zero;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             dmem_req;
    logic             mem_write;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       npc_sel;
    logic             reg_we;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic             alu_src;
    logic             ext_op;
    logic [2:0]       alu_ctrl;
    logic [2:0]       state;
    logic             halted;
    logic             bus_err;
    logic             illegal;
    logic [CNT_W-1:0] instret;

    modport master (
        input  instr, zero, imem_ready, dmem_ready,
        output imem_req, dmem_req, mem_write, ir_we, pc_we, npc_sel, reg_we, reg_dst,
               mem_to_reg, alu_src, ext_op, alu_ctrl, state, halted, bus_err, illegal, instret
    );
    modport slave (
        output instr, zero, imem_ready, dmem_ready,
        input  imem_req, dmem_req, mem_write, ir_we, pc_we, npc_sel, reg_we, reg_dst,
               mem_to_reg, alu_src, ext_op, alu_ctrl, state, halted, bus_err, illegal, instret
    );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS controller with memory handshakes, timeout, sticky halt and instret.
module mc_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 32
) (
    input logic    clk,
    input logic    reset,
    mc_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'b000,
        DECODE = 3'b001,
        EXEC   = 3'b010,
        MEM    = 3'b011,
        WB     = 3'b100,
        HALT   = 3'b111
    } state_e;

    state_e           state_q, state_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0] instret_q;
    logic             bus_err_q, illegal_q;
    logic [5:0]       op, fn;
    logic             i_addu, i_subu, i_jr, i_ori, i_lw, i_sw, i_beq, i_lui, i_jal, i_rt;
    logic             legal, req_wait, to_hit, retire, run, unused_ok;

    assign op        = bus.instr[31:26];
    assign fn        = bus.instr[5:0];
    assign unused_ok = ^bus.instr[25:6];
    assign i_rt      = op == 6'h00;
    assign i_addu    = i_rt && fn == 6'h21;
    assign i_subu    = i_rt && fn == 6'h23;
    assign i_jr      = i_rt && fn == 6'h08;
    assign i_ori     = op == 6'h0d;
    assign i_lw      = op == 6'h23;
    assign i_sw      = op == 6'h2b;
    assign i_beq     = op == 6'h04;
    assign i_lui     = op == 6'h0f;
    assign i_jal     = op == 6'h03;
    assign legal     = i_addu | i_subu | i_jr | i_ori | i_lw | i_sw | i_beq | i_lui | i_jal;

    // a ready arriving in the timeout cycle completes normally, since to_hit needs ready low
    assign req_wait = (state_q == FETCH && !bus.imem_ready) || (state_q == MEM && !bus.dmem_ready);
    assign to_hit   = (MEM_TIMEOUT != 0) && req_wait && (cnt_q == TO_W'(MEM_TIMEOUT));
    assign retire   = (state_q == EXEC && (i_beq || i_jr || i_jal)) ||
                      (state_q == MEM && i_sw && bus.dmem_ready) || state_q == WB;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = to_hit ? HALT : bus.imem_ready ? DECODE : FETCH;
            DECODE:  state_d = legal ? EXEC : HALT;
            EXEC:    state_d = (i_lw || i_sw) ? MEM : (i_beq || i_jr || i_jal) ? FETCH : WB;
            MEM:     state_d = to_hit ? HALT : !bus.dmem_ready ? MEM : i_sw ? FETCH : WB;
            WB:      state_d = FETCH;
            default: state_d = HALT;
        endcase
    end

    assign cnt_d = (state_d != state_q || !req_wait) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            instret_q <= '0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            instret_q <= instret_q + CNT_W'(retire);
            bus_err_q <= bus_err_q | to_hit;
            illegal_q <= illegal_q | (state_q == DECODE && !legal);
        end
    end

    // enables are gated by reset so an abandoned instruction has no side effects
    assign run            = !reset;
    assign bus.imem_req   = run && state_q == FETCH;
    assign bus.ir_we      = run && state_q == FETCH && bus.imem_ready;
    assign bus.dmem_req   = run && state_q == MEM;
    assign bus.mem_write  = run && state_q == MEM && i_sw;
    assign bus.pc_we      = run && ((state_q == FETCH && bus.imem_ready) ||
                            (state_q == EXEC && ((i_beq && bus.zero) || i_jr || i_jal)));
    assign bus.reg_we     = run && (state_q == WB || (state_q == EXEC && i_jal));
    assign bus.npc_sel    = state_q != EXEC ? 2'b00 : i_beq ? 2'b01 : i_jal ? 2'b10 : i_jr ? 2'b11 : 2'b00;
    assign bus.reg_dst    = i_jal ? 2'b10 : i_rt ? 2'b01 : 2'b00;
    assign bus.mem_to_reg = i_lw ? 2'b01 : i_lui ? 2'b10 : i_jal ? 2'b11 : 2'b00;
    assign bus.alu_src    = i_ori | i_lw | i_sw;
    assign bus.ext_op     = i_ori;
    assign bus.alu_ctrl   = i_ori ? 3'b001 : (i_addu || i_lw || i_sw || i_jr) ? 3'b010 :
                            (i_subu || i_beq) ? 3'b011 : 3'b111;
    assign bus.state      = state_q;
    assign bus.halted     = state_q == HALT;
    assign bus.bus_err    = bus_err_q;
    assign bus.illegal    = illegal_q;
    assign bus.instret    = instret_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench; per-cycle expected control words are queued per instruction and popped as the DUT steps.
module tb_mc_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [1:0] exp_ret = 2'd0;

    typedef struct {
        logic [2:0] st;
        logic [5:0] en;
        logic [1:0] npc;
        logic       cnpc;
        logic       mw;
        logic       irdy;
        logic       drdy;
    } rec_t;
    rec_t q[$];

    mc_ctrl_if #(.CNT_W(2)) bus ();
    mc_ctrl #(.MEM_TIMEOUT(4), .TO_W(8), .CNT_W(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push(input logic [2:0] st, input logic [5:0] en, input logic [1:0] npc,
                                 input logic cnpc, input logic mw, input logic irdy, input logic drdy);
        rec_t r;
        r.st = st; r.en = en; r.npc = npc; r.cnpc = cnpc; r.mw = mw; r.irdy = irdy; r.drdy = drdy;
        q.push_back(r);
    endfunction

    task automatic drive_q(input logic [31:0] ins, input logic z, input logic [8:0] sel);
        rec_t e;
        bus.instr = ins;
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            bus.imem_ready = e.irdy;
            bus.dmem_ready = e.drdy;
            bus.zero = z;
            #1;
            chk("state", bus.state, e.st);
            chk("en", {bus.imem_req, bus.dmem_req, bus.ir_we, bus.pc_we, bus.reg_we, bus.halted}, e.en);
            if (e.cnpc) chk("npc", bus.npc_sel, e.npc);
            if (e.st == 3'd3) chk("mem_write", bus.mem_write, e.mw);
            if (e.st >= 3'd2 && e.st <= 3'd4)
                chk("sel", {bus.reg_dst, bus.mem_to_reg, bus.alu_src, bus.ext_op, bus.alu_ctrl}, sel);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b1;
        #1;
        chk("rst_en", {bus.imem_req, bus.dmem_req, bus.mem_write, bus.ir_we, bus.pc_we, bus.reg_we}, 0);
        @(posedge clk);
        #1;
        chk("rst_flags", {bus.state, bus.halted, bus.bus_err, bus.illegal}, 0);
        chk("rst_instret", bus.instret, 0);
        @(negedge clk);
        reset = 1'b0;
        bus.imem_ready = 1'b0;
        #1;
        chk("rel_req", {bus.imem_req, bus.state}, {1'b1, 3'b000});
        exp_ret = 2'd0;
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic z, input int dwait);
        logic [5:0] op, fn;
        logic addu, subu, jr, ori, lw, sw, beq, lui, jal, ctl;
        logic [8:0] sel;
        op = ins[31:26];
        fn = ins[5:0];
        addu = op == 6'h00 && fn == 6'h21;
        subu = op == 6'h00 && fn == 6'h23;
        jr   = op == 6'h00 && fn == 6'h08;
        ori  = op == 6'h0d;
        lw   = op == 6'h23;
        sw   = op == 6'h2b;
        beq  = op == 6'h04;
        lui  = op == 6'h0f;
        jal  = op == 6'h03;
        ctl  = beq | jr | jal;
        sel = {jal ? 2'b10 : op == 6'h00 ? 2'b01 : 2'b00,
               lw ? 2'b01 : lui ? 2'b10 : jal ? 2'b11 : 2'b00,
               ori | lw | sw, ori,
               ori ? 3'b001 : (addu | lw | sw | jr) ? 3'b010 : (subu | beq) ? 3'b011 : 3'b111};
        push(3'd0, 6'b101100, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
        push(3'd1, 6'b000000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        push(3'd2, {3'b000, beq ? z : (jr | jal), jal, 1'b0},
             beq ? 2'b01 : jal ? 2'b10 : 2'b11, ctl, 1'b0, 1'b1, 1'b1);
        if (lw | sw) begin
            for (int i = 0; i < dwait; i++) push(3'd3, 6'b010000, 2'b00, 1'b0, sw, 1'b1, 1'b0);
            push(3'd3, 6'b010000, 2'b00, 1'b0, sw, 1'b1, 1'b1);
        end
        if (!(sw | ctl)) push(3'd4, 6'b000010, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        drive_q(ins, z, sel);
        exp_ret = exp_ret + 2'd1;
        @(posedge clk);
        #1;
        chk("instret", bus.instret, exp_ret);
        chk("next_fetch", bus.state, 3'd0);
    endtask

    task automatic run_illegal(input logic [31:0] ins);
        push(3'd0, 6'b101100, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
        push(3'd1, 6'b000000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        push(3'd7, 6'b000001, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        push(3'd7, 6'b000001, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        drive_q(ins, 1'b0, 9'd0);
        chk("illegal_flags", {bus.illegal, bus.bus_err, bus.mem_write}, 3'b100);
        chk("illegal_instret", bus.instret, exp_ret);
        do_reset();
    endtask

    initial begin
        bus.instr = 32'h0;
        bus.zero = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        do_reset();
        run_instr(32'h00221821, 1'b0, 0);  // addu
        run_instr(32'h00221823, 1'b0, 0);  // subu
        run_instr(32'h34221234, 1'b0, 0);  // ori
        run_instr(32'h3c021234, 1'b0, 0);  // lui, instret wraps to 0
        run_instr(32'h8c220004, 1'b0, 3);  // lw, 3 wait cycles
        run_instr(32'hac220004, 1'b0, 0);  // sw
        run_instr(32'hac220004, 1'b0, 4);  // sw, ready in the timeout cycle
        run_instr(32'h10220003, 1'b1, 0);  // beq taken
        run_instr(32'h10220003, 1'b0, 0);  // beq not taken
        run_instr(32'h03e00008, 1'b0, 0);  // jr
        run_instr(32'h0c000010, 1'b0, 0);  // jal
        for (int i = 0; i < 5; i++) push(3'd0, 6'b100000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        push(3'd7, 6'b000001, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        push(3'd7, 6'b000001, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        drive_q(32'h00221821, 1'b0, 9'd0);
        chk("timeout_flags", {bus.bus_err, bus.illegal}, 2'b10);
        do_reset();
        run_illegal(32'hfc000000);
        run_illegal(32'h00221820);
        push(3'd0, 6'b101100, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
        push(3'd1, 6'b000000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        push(3'd2, 6'b000000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        drive_q(32'h00221821, 1'b0, 9'b01_00_0_0_010);
        do_reset();
        run_instr(32'h00221821, 1'b0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
